// File: rtl/uart_rx_deserializer_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver sequencing states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Payload width of an 8N1 frame
    localparam int unsigned UART_DATA_BITS = 8;

endpackage : uart_pkg

// File: rtl/uart_rx_deserializer_bit_timer.sv
// Bit-period timer for the UART receiver.
// Counts clkIn cycles and emits a one-cycle sample strobe either at the
// half-bit point (start-bit centring) or at the end of a full bit period.
// The count restarts after every strobe, so consecutive data bits are
// sampled exactly one bit period apart without outside help.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clkIn,
    input  logic nResetIn,
    input  logic clearIn,
    input  logic halfSelIn,
    output logic strobeOut
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : gBadClksPerBit
            $error("uart_bit_timer: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lastCnt;

    assign lastCnt   = halfSelIn ? HALF_LAST : FULL_LAST;
    assign strobeOut = !clearIn && (cnt == lastCnt);

    // Cycle counter: held at zero while cleared, wraps after each strobe
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            cnt <= '0;
        end else if (clearIn || strobeOut) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : uart_bit_timer

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver fed by the majority-filtered rx line.
// Emits each correctly framed byte as a one-cycle validOut pulse with the
// byte on dataOut; a zero stop bit gives a one-cycle frameErrOut pulse and
// the receiver then waits for the line to go high again so that a held-low
// (break) line cannot produce a stream of bogus frames.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                      clkIn,
    input  logic                      nResetIn,
    input  logic                      rxIn,
    output logic [UART_DATA_BITS-1:0] dataOut,
    output logic                      validOut,
    output logic                      frameErrOut,
    output logic                      busyOut
);

    localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : gBadClksPerBit
            $error("uart_rx_deserializer: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    uart_rx_state_t            state;
    logic [BIT_IDX_W-1:0]      bitIdx;
    logic [UART_DATA_BITS-1:0] shiftReg;

    logic timerClear;
    logic timerHalf;
    logic sampleStrobe;

    // The timer is parked in the states that wait on the line itself; every
    // other state change happens on a strobe, which also restarts the count.
    assign timerClear = (state == IDLE) || (state == BREAK);
    assign timerHalf  = (state == START);
    assign busyOut    = (state != IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) bitTimer (
        .clkIn    (clkIn),
        .nResetIn (nResetIn),
        .clearIn  (timerClear),
        .halfSelIn(timerHalf),
        .strobeOut(sampleStrobe)
    );

    // Frame sequencer with shift register and registered output pulses
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            state       <= IDLE;
            bitIdx      <= '0;
            shiftReg    <= '0;
            dataOut     <= '0;
            validOut    <= 1'b0;
            frameErrOut <= 1'b0;
        end else begin
            validOut    <= 1'b0;
            frameErrOut <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rxIn) begin
                        state <= START;
                    end
                end
                START: begin
                    if (sampleStrobe) begin
                        if (!rxIn) begin
                            state  <= DATA;
                            bitIdx <= '0;
                        end else begin
                            // Line back high at mid start bit: glitch, drop it
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sampleStrobe) begin
                        shiftReg <= {rxIn, shiftReg[UART_DATA_BITS-1:1]};
                        bitIdx   <= bitIdx + 1'b1;
                        if (bitIdx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (sampleStrobe) begin
                        if (rxIn) begin
                            dataOut  <= shiftReg;
                            validOut <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frameErrOut <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxIn) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_rx_deserializer

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (CLKS_PER_BIT = 16 and 17).
// Expected output events are derived from frame-level rules: a frame whose
// start bit is first seen at edge T0 reports at T0 + HALF + 9*CPB, either a
// valid byte (stop = 1) or a frame error with the previous good byte held.
module tb_uart_rx_deserializer;

    localparam int CPB16  = 16;
    localparam int HALF16 = CPB16 / 2;
    localparam int CPB17  = 17;
    localparam int HALF17 = CPB17 / 2;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx17 = 1'b1;
    logic [7:0] d16, d17;
    logic       v16, fe16, b16;
    logic       v17, fe17, b17;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        int         cyc;
        bit         err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        int         gap;
        bit         expErr;
        logic [7:0] expData;
    } vec_t;

    ev_t expQ[$];
    ev_t obsQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB16)) dut16 (
        .clkIn      (clk),
        .nResetIn   (nReset),
        .rxIn       (rx16),
        .dataOut    (d16),
        .validOut   (v16),
        .frameErrOut(fe16),
        .busyOut    (b16)
    );

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB17)) dut17 (
        .clkIn      (clk),
        .nResetIn   (nReset),
        .rxIn       (rx17),
        .dataOut    (d17),
        .validOut   (v17),
        .frameErrOut(fe17),
        .busyOut    (b17)
    );

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (v16 || fe16) begin
            obsQ.push_back('{0, cyc, fe16, d16});
            checks++;
            if (v16 && fe16) begin
                errors++;
                $display("FAIL exclusive16 at cycle %0d: valid=%0b frameErr=%0b, required not both", cyc, v16, fe16);
            end
        end
        if (v17 || fe17) begin
            obsQ.push_back('{1, cyc, fe17, d17});
            checks++;
            if (v17 && fe17) begin
                errors++;
                $display("FAIL exclusive17 at cycle %0d: valid=%0b frameErr=%0b, required not both", cyc, v17, fe17);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle16(input int n);
        rx16 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame on rx16; starts and ends 1 time unit after a posedge
    task automatic sendFrame16(input logic [7:0] b, input bit stopBit, output int t0);
        logic [9:0] fr;
        fr = {stopBit, b, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx16 = fr[i];
            repeat (CPB16) @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame on rx17 with bit period scaled by pct100/100 (1751 = +3%)
    task automatic sendFrame17(input logic [7:0] b, input int pct100, output int t0);
        logic [9:0] fr;
        int total;
        int j;
        fr = {1'b1, b, 1'b0};
        t0 = cyc + 1;
        total = (10 * pct100 + 50) / 100 + 4;
        for (int k = 0; k < total; k++) begin
            j = 0;
            while (j < 10 && (((j + 1) * pct100 + 50) / 100) <= k) j++;
            rx17 = (j >= 10) ? 1'b1 : fr[j];
            @(posedge clk);
            #1;
        end
        rx17 = 1'b1;
    endtask

    task automatic pushExp(input int dut, input int t0, input bit err, input logic [7:0] data);
        if (dut == 0) expQ.push_back('{0, t0 + HALF16 + 9 * CPB16, err, data});
        else          expQ.push_back('{1, t0 + HALF17 + 9 * CPB17, err, data});
    endtask

    task automatic compareEvents(input string name);
        ev_t e;
        ev_t o;
        while (expQ.size() > 0 || obsQ.size() > 0) begin
            checks++;
            if (expQ.size() == 0) begin
                o = obsQ.pop_front();
                errors++;
                $display("FAIL %s unexpected event: dut%0d cycle %0d err=%0b data=0x%02h, required none", name, o.dut, o.cyc, o.err, o.data);
            end else if (obsQ.size() == 0) begin
                e = expQ.pop_front();
                errors++;
                $display("FAIL %s missing event: got none, required dut%0d cycle %0d err=%0b data=0x%02h", name, e.dut, e.cyc, e.err, e.data);
            end else begin
                e = expQ.pop_front();
                o = obsQ.pop_front();
                if (e.dut != o.dut || e.cyc != o.cyc || e.err != o.err || e.data !== o.data) begin
                    errors++;
                    $display("FAIL %s event: got dut%0d cycle %0d err=%0b data=0x%02h, required dut%0d cycle %0d err=%0b data=0x%02h",
                             name, o.dut, o.cyc, o.err, o.data, e.dut, e.cyc, e.err, e.data);
                end
            end
        end
    endtask

    initial begin
        vec_t       vecs[5];
        int         t0, t1, busyCnt, gap, hold, gl;
        logic [7:0] lastGood;
        logic [7:0] b;
        bit         stopBit;

        vecs[0] = '{8'h55, 1'b1, 0, 1'b0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 3, 1'b0, 8'hFF};
        vecs[3] = '{8'hA3, 1'b0, 5, 1'b1, 8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 0, 1'b0, 8'h5A};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data16", d16, 8'h00);
        chk("reset_valid16", v16, 1'b0);
        chk("reset_ferr16", fe16, 1'b0);
        chk("reset_busy16", b16, 1'b0);
        chk("reset_data17", d17, 8'h00);
        chk("reset_busy17", b17, 1'b0);
        nReset = 1'b1;
        idle16(5);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            sendFrame16(vecs[i].data, vecs[i].stopBit, t0);
            pushExp(0, t0, vecs[i].expErr, vecs[i].expData);
            idle16(vecs[i].gap);
        end
        idle16(20);
        compareEvents("table");

        // Single 0x55 frame, busy low right after the pulse
        sendFrame16(8'h55, 1'b1, t0);
        pushExp(0, t0, 1'b0, 8'h55);
        chk("busy_after_pulse", b16, 1'b0);
        idle16(4);
        compareEvents("frame55");
        lastGood = 8'h55;

        // Start-bit glitch: three low cycles
        busyCnt = 0;
        rx16 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (b16) busyCnt++;
            if (i == 2) rx16 = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("glitch_busy_cycles", busyCnt, 8);
        chk("glitch_data_held", d16, lastGood);
        compareEvents("glitch");

        // Frame error followed by a held-low line
        sendFrame16(8'hA3, 1'b0, t0);
        pushExp(0, t0, 1'b1, lastGood);
        repeat (40) @(posedge clk);
        #1;
        chk("break_busy_held", b16, 1'b1);
        rx16 = 1'b1;
        @(posedge clk);
        #1;
        chk("break_busy_released", b16, 1'b0);
        chk("break_data_held", d16, lastGood);
        idle16(4);
        compareEvents("break");

        // Back-to-back frames without idle gap
        sendFrame16(8'h00, 1'b1, t0);
        sendFrame16(8'hFF, 1'b1, t1);
        pushExp(0, t0, 1'b0, 8'h00);
        pushExp(0, t1, 1'b0, 8'hFF);
        idle16(4);
        checks++;
        if (obsQ.size() < 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d events, required 2", obsQ.size());
        end else if (obsQ[1].cyc - obsQ[0].cyc != 160) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, required 160", obsQ[1].cyc - obsQ[0].cyc);
        end
        compareEvents("back2back");

        // Asynchronous reset during data bit 4
        rx16 = 1'b0;
        repeat (CPB16) @(posedge clk);
        #1;
        b = 8'h96;
        for (int i = 0; i < 3; i++) begin
            rx16 = b[i];
            repeat (CPB16) @(posedge clk);
            #1;
        end
        rx16 = b[3];
        repeat (7) @(posedge clk);
        #1;
        nReset = 1'b0;
        #2;
        chk("midreset_data", d16, 8'h00);
        chk("midreset_valid", v16, 1'b0);
        chk("midreset_ferr", fe16, 1'b0);
        chk("midreset_busy", b16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rx16 = 1'b1;
        nReset = 1'b1;
        idle16(20);
        sendFrame16(8'h3C, 1'b1, t0);
        pushExp(0, t0, 1'b0, 8'h3C);
        idle16(4);
        compareEvents("after_reset");
        lastGood = 8'h3C;

        // Randomised frames, frame errors and glitches
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            stopBit = ($urandom_range(0, 4) != 0);
            sendFrame16(b, stopBit, t0);
            if (stopBit) begin
                lastGood = b;
                pushExp(0, t0, 1'b0, b);
                gap = $urandom_range(0, 10);
            end else begin
                pushExp(0, t0, 1'b1, lastGood);
                hold = $urandom_range(0, 20);
                repeat (hold) @(posedge clk);
                #1;
                gap = $urandom_range(1, 10);
            end
            idle16(gap);
            if ($urandom_range(0, 3) == 0) begin
                gl = $urandom_range(1, HALF16 - 1);
                rx16 = 1'b0;
                repeat (gl) @(posedge clk);
                #1;
                idle16(10);
            end
        end
        idle16(20);
        compareEvents("random");

        // CLKS_PER_BIT = 17: nominal and +3% stretched bit timing
        sendFrame17(8'h6B, 1700, t0);
        pushExp(1, t0, 1'b0, 8'h6B);
        repeat (10) @(posedge clk);
        #1;
        sendFrame17(8'hC9, 1751, t0);
        pushExp(1, t0, 1'b0, 8'hC9);
        repeat (10) @(posedge clk);
        #1;
        chk("cpb17_data", d17, 8'hC9);
        chk("cpb17_busy", b17, 1'b0);
        compareEvents("cpb17");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_deserializer
